// File: rtl/isp_pkg.sv
// Shared ISP constants and helpers: luma weights, frame geometry, RGB565 field
// layout and the luma pipeline depth used by downstream stages for delay matching.
package isp_pkg;

  localparam int unsigned COEF_R_DEF = 77;
  localparam int unsigned COEF_G_DEF = 150;
  localparam int unsigned COEF_B_DEF = 29;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;

  localparam int unsigned Y_LAT = 3;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_end;
    logic           frame_end;
  } pix_tag_t;

  // Replicate the field MSBs into the vacated LSBs so full scale maps to 255.
  function automatic rgb888_t expand565(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[R_MSB:R_LSB], p[R_MSB -: 3]};
    c.g = {p[G_MSB:G_LSB], p[G_MSB -: 2]};
    c.b = {p[B_MSB:B_LSB], p[B_MSB -: 3]};
    return c;
  endfunction

endpackage

// File: rtl/rgb565_to_y_if.sv
// Pixel-in / luma-out bundle for rgb565_to_y; the gray_rgb565 bypass exists
// only when RGB565_TO_Y_GRAY_OUT_EN is defined.
interface rgb565_to_y_if;
  logic        frame_start;
  logic        wr_en;
  logic [15:0] data_in;
  logic [7:0]  img_Y;
  logic        y_wr_en;
  logic        line_end;
  logic        frame_end;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
`ifdef RGB565_TO_Y_GRAY_OUT_EN
  logic [15:0] gray_rgb565;
`endif

  modport master (
`ifdef RGB565_TO_Y_GRAY_OUT_EN
    input  gray_rgb565,
`endif
    output frame_start, wr_en, data_in,
    input  img_Y, y_wr_en, line_end, frame_end, pix_x, pix_y
  );

  modport slave (
`ifdef RGB565_TO_Y_GRAY_OUT_EN
    output gray_rgb565,
`endif
    input  frame_start, wr_en, data_in,
    output img_Y, y_wr_en, line_end, frame_end, pix_x, pix_y
  );
endinterface

// File: rtl/rgb565_to_y_pix_pos_counter.sv
// Horizontal/vertical pixel position counters with wrap and frame_start clear;
// emits the position tag and line/frame end flags of the pixel currently at input.
module pix_pos_counter
  import isp_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     frame_start,
  input  logic     wr_en,
  output pix_tag_t tag
);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           last_x;
  logic           last_y;

  // frame_start overrides the counters combinationally so a coincident pixel is tagged (0,0).
  always_comb begin
    cur_x         = frame_start ? '0 : h_cnt;
    cur_y         = frame_start ? '0 : v_cnt;
    last_x        = (cur_x == X_W'(IMG_W - 1));
    last_y        = (cur_y == Y_W'(IMG_H - 1));
    tag.x         = cur_x;
    tag.y         = cur_y;
    tag.line_end  = last_x;
    tag.frame_end = last_x && last_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (wr_en) begin
      if (last_x) begin
        h_cnt <= '0;
        v_cnt <= last_y ? '0 : cur_y + Y_W'(1);
      end else begin
        h_cnt <= cur_x + X_W'(1);
        v_cnt <= cur_y;
      end
    end else if (frame_start) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

endmodule

// File: rtl/rgb565_to_y.sv
// Three-stage RGB565 -> 8-bit luma pipeline with position tags aligned to y_wr_en.
// Optional gray_rgb565 display bypass under RGB565_TO_Y_GRAY_OUT_EN.
module rgb565_to_y
  import isp_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned COEF_R = COEF_R_DEF,
  parameter int unsigned COEF_G = COEF_G_DEF,
  parameter int unsigned COEF_B = COEF_B_DEF
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  rgb565_to_y_if.slave bus
);

  rgb888_t     px;
  pix_tag_t    tag_in;
  pix_tag_t    tag1;
  pix_tag_t    tag2;
  logic        v1;
  logic        v2;
  logic [15:0] prod_r;
  logic [15:0] prod_g;
  logic [15:0] prod_b;
  logic [15:0] sum;
  logic        sum_lsb_unused;

  pix_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .frame_start (bus.frame_start),
    .wr_en       (bus.wr_en),
    .tag         (tag_in)
  );

  always_comb px = expand565(bus.data_in);

  // Weights sum to 256, so the truncated result needs only the top byte.
  always_comb sum_lsb_unused = ^sum[7:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      prod_r        <= '0;
      prod_g        <= '0;
      prod_b        <= '0;
      tag1          <= '0;
      sum           <= '0;
      tag2          <= '0;
      bus.y_wr_en   <= 1'b0;
      bus.img_Y     <= '0;
      bus.pix_x     <= '0;
      bus.pix_y     <= '0;
      bus.line_end  <= 1'b0;
      bus.frame_end <= 1'b0;
`ifdef RGB565_TO_Y_GRAY_OUT_EN
      bus.gray_rgb565 <= '0;
`endif
    end else begin
      v1          <= bus.wr_en;
      v2          <= v1;
      bus.y_wr_en <= v2;

      if (bus.wr_en) begin
        prod_r <= 16'(COEF_R) * {8'd0, px.r};
        prod_g <= 16'(COEF_G) * {8'd0, px.g};
        prod_b <= 16'(COEF_B) * {8'd0, px.b};
        tag1   <= tag_in;
      end

      if (v1) begin
        sum  <= prod_r + prod_g + prod_b;
        tag2 <= tag1;
      end

      if (v2) begin
        bus.img_Y <= sum[15:8];
        bus.pix_x <= tag2.x;
        bus.pix_y <= tag2.y;
`ifdef RGB565_TO_Y_GRAY_OUT_EN
        bus.gray_rgb565 <= {sum[15:11], sum[15:10], sum[15:11]};
`endif
      end

      // End flags are strobes: gated by stage validity rather than held.
      bus.line_end  <= v2 & tag2.line_end;
      bus.frame_end <= v2 & tag2.frame_end;
    end
  end

endmodule

// File: tb/tb_rgb565_to_y.sv
// Self-checking bench for rgb565_to_y on a 4x2 frame: directed vectors against a
// queue-based luma/position model compared every cycle on the falling edge.
module tb_rgb565_to_y;
  import isp_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  rgb565_to_y_if bus ();

  rgb565_to_y #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int due;
    int y;
    int x;
    int row;
    bit le;
    bit fe;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   pos       = 0;
  int   last_y    = 0;
  int   last_x    = 0;
  int   last_row  = 0;
  int   last_gray = 0;
  int   fe_seen   = 0;
  int   le_seen   = 0;
  int   n_vec     = 0;
  int   n_err     = 0;

  function automatic int y_of(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p >> 11) & 31;
    g6 = int'(p >> 5) & 63;
    b5 = int'(p) & 31;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  function automatic int gray_of(input int y);
    return ((y / 8) * 2048) + ((y / 4) * 32) + (y / 8);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic chk_all_zero(input string tagname);
    chk({tagname, "_y_wr_en"}, int'(bus.y_wr_en), 0);
    chk({tagname, "_img_Y"}, int'(bus.img_Y), 0);
    chk({tagname, "_line_end"}, int'(bus.line_end), 0);
    chk({tagname, "_frame_end"}, int'(bus.frame_end), 0);
    chk({tagname, "_pix_x"}, int'(bus.pix_x), 0);
    chk({tagname, "_pix_y"}, int'(bus.pix_y), 0);
`ifdef RGB565_TO_Y_GRAY_OUT_EN
    chk({tagname, "_gray"}, int'(bus.gray_rgb565), 0);
`endif
  endtask

  // Model: linear pixel index since frame_start, tags derived by div/mod.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        q.delete();
        cyc = 0; pos = 0;
        last_y = 0; last_x = 0; last_row = 0; last_gray = 0;
      end else begin
        cyc++;
        if (bus.frame_start) pos = 0;
        if (bus.wr_en) begin
          e.due = cyc + int'(Y_LAT) - 1;
          e.y   = y_of(bus.data_in);
          e.x   = pos % int'(W);
          e.row = (pos / int'(W)) % int'(H);
          e.le  = (e.x == int'(W) - 1);
          e.fe  = (pos % int'(W * H)) == int'(W * H) - 1;
          q.push_back(e);
          pos++;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (bus.frame_end) fe_seen++;
      if (bus.line_end)  le_seen++;
      if (!sys_rst_n) begin
        chk_all_zero("in_reset");
      end else if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("y_wr_en", int'(bus.y_wr_en), 1);
        chk("img_Y", int'(bus.img_Y), e.y);
        chk("pix_x", int'(bus.pix_x), e.x);
        chk("pix_y", int'(bus.pix_y), e.row);
        chk("line_end", int'(bus.line_end), int'(e.le));
        chk("frame_end", int'(bus.frame_end), int'(e.fe));
`ifdef RGB565_TO_Y_GRAY_OUT_EN
        chk("gray", int'(bus.gray_rgb565), gray_of(e.y));
        last_gray = gray_of(e.y);
`endif
        last_y = e.y; last_x = e.x; last_row = e.row;
      end else begin
        chk("idle_y_wr_en", int'(bus.y_wr_en), 0);
        chk("idle_line_end", int'(bus.line_end), 0);
        chk("idle_frame_end", int'(bus.frame_end), 0);
        chk("hold_img_Y", int'(bus.img_Y), last_y);
        chk("hold_pix_x", int'(bus.pix_x), last_x);
        chk("hold_pix_y", int'(bus.pix_y), last_row);
`ifdef RGB565_TO_Y_GRAY_OUT_EN
        chk("hold_gray", int'(bus.gray_rgb565), last_gray);
`endif
      end
    end
  end

  task automatic px(input logic fs, input logic we, input logic [15:0] d);
    @(posedge sys_clk);
    #2;
    bus.frame_start = fs;
    bus.wr_en       = we;
    bus.data_in     = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [15:0] d;
    bus.frame_start = 1'b0;
    bus.wr_en       = 1'b0;
    bus.data_in     = 16'h0000;

    chk("model_y_white", y_of(16'hFFFF), 255);
    chk("model_y_black", y_of(16'h0000), 0);
    chk("model_y_red",   y_of(16'hF800), 76);
    chk("model_y_green", y_of(16'h07E0), 149);
    chk("model_y_blue",  y_of(16'h001F), 28);
    chk("model_gray_76", gray_of(76), 16'h4A69);
    chk("model_gray_255", gray_of(255), 16'hFFFF);

    repeat (3) @(posedge sys_clk);
    #1;
    chk_all_zero("reset");
    #1 sys_rst_n = 1'b1;

    // colour bars
    px(1'b1, 1'b0, 16'h0000);
    px(1'b0, 1'b1, 16'hFFFF);
    px(1'b0, 1'b1, 16'h0000);
    px(1'b0, 1'b1, 16'hF800);
    px(1'b0, 1'b1, 16'h07E0);
    px(1'b0, 1'b1, 16'h001F);
    idle(5);
    chk("bars_hold_Y", int'(bus.img_Y), 28);

    // gapped input
    px(1'b1, 1'b0, 16'h0000);
    px(1'b0, 1'b1, 16'hF800);
    idle(2);
    px(1'b0, 1'b1, 16'h07E0);
    idle(4);
    chk("gap_final_Y", int'(bus.img_Y), 149);

    // full 4x2 frame plus one wrapped pixel
    px(1'b1, 1'b0, 16'h0000);
    fe_seen = 0; le_seen = 0;
    d = 16'h1234;
    for (int i = 0; i < 9; i++) begin
      px(1'b0, 1'b1, d);
      d = d + 16'h2357;
    end
    idle(4);
    chk("frame_end_count", fe_seen, 1);
    chk("line_end_count", le_seen, 2);
    chk("wrap_pix_x", int'(bus.pix_x), 0);
    chk("wrap_pix_y", int'(bus.pix_y), 0);

    // frame_start coincident with a mid-line pixel
    px(1'b1, 1'b0, 16'h0000);
    fe_seen = 0;
    px(1'b0, 1'b1, 16'hAAAA);
    px(1'b0, 1'b1, 16'h5555);
    px(1'b0, 1'b1, 16'h0F0F);
    px(1'b1, 1'b1, 16'hF800);
    px(1'b0, 1'b1, 16'h07E0);
    idle(4);
    chk("simul_no_frame_end", fe_seen, 0);
    chk("simul_pix_x", int'(bus.pix_x), 1);
    chk("simul_pix_y", int'(bus.pix_y), 0);

    // reset with three pixels in flight
    px(1'b0, 1'b1, 16'hFFFF);
    px(1'b0, 1'b1, 16'h07E0);
    px(1'b0, 1'b1, 16'h001F);
    @(posedge sys_clk);
    #1;
    bus.wr_en = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    px(1'b1, 1'b1, 16'hF800);
    idle(4);
    chk("post_reset_Y", int'(bus.img_Y), 76);
    chk("post_reset_pix_x", int'(bus.pix_x), 0);
    chk("post_reset_pix_y", int'(bus.pix_y), 0);
`ifdef RGB565_TO_Y_GRAY_OUT_EN
    chk("post_reset_gray", int'(bus.gray_rgb565), 16'h4A69);
`endif

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
